// File: rtl/fetch_unit.sv
// Fetch-group producer: sequential PC generation, one-outstanding I-cache requests,
// response FIFO toward ibuffer, and redirect handling that drops stale in-flight groups.

module fetch_unit_chk #(
  parameter int unsigned RSP_DEPTH = 4,
  parameter int unsigned CNT_W     = 3
) (
  input logic             clk_i,
  input logic             rst_ni,
  input logic             push_s,
  input logic             pop_s,
  input logic [CNT_W-1:0] count_r
);

  // A push into a full FIFO without a simultaneous pop is a credit-logic bug.
  overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_s && !pop_s && (count_r == CNT_W'(RSP_DEPTH))))
    else $error("fetch_unit response FIFO overflow");

endmodule

module fetch_unit #(
  parameter int unsigned     INSTR_PER_FETCH = 4,
  parameter int unsigned     ILEN            = 32,
  parameter int unsigned     PLEN            = 32,
  parameter logic [PLEN-1:0] RESET_PC        = 32'h8000_0000,
  parameter int unsigned     RSP_DEPTH       = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            redirect_i,
  input  logic [PLEN-1:0]                 redirect_pc_i,
  output logic                            ic_req_valid_o,
  input  logic                            ic_req_ready_i,
  output logic [PLEN-1:0]                 ic_req_addr_o,
  input  logic                            ic_rsp_valid_i,
  input  logic [INSTR_PER_FETCH*ILEN-1:0] ic_rsp_instrs_i,
  output logic                            fe_valid_o,
  input  logic                            fe_ready_i,
  output logic [INSTR_PER_FETCH*ILEN-1:0] fe_instrs_o,
  output logic [PLEN-1:0]                 fe_pc_o
);

  localparam int unsigned     GW          = INSTR_PER_FETCH * ILEN;
  localparam int unsigned     FETCH_BYTES = GW / 8;
  localparam int unsigned     PTR_W       = $clog2(RSP_DEPTH);
  localparam int unsigned     CNT_W       = $clog2(RSP_DEPTH + 1);
  localparam logic [PLEN-1:0] FETCH_INC   = PLEN'(FETCH_BYTES);
  localparam logic [CNT_W:0]  DEPTH_C     = (CNT_W + 1)'(RSP_DEPTH);

  logic [PLEN-1:0]  npc_r;
  logic [PLEN-1:0]  req_pc_r;
  logic             outstanding_r;
  logic             drop_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [PLEN-1:0]  pc_mem_r  [RSP_DEPTH];
  logic [GW-1:0]    ins_mem_r [RSP_DEPTH];

  logic rsp_fire_s;
  logic credit_ok_s;
  logic req_fire_s;
  logic push_s;
  logic pop_s;

  // Handshake decode; the credit check looks only at registered occupancy.
  always_comb begin
    rsp_fire_s     = ic_rsp_valid_i;
    credit_ok_s    = (({1'b0, count_r} + {{CNT_W{1'b0}}, outstanding_r}) < DEPTH_C);
    ic_req_valid_o = rst_ni && !redirect_i && (!outstanding_r || rsp_fire_s) && credit_ok_s;
    req_fire_s     = ic_req_valid_o && ic_req_ready_i;
    fe_valid_o     = (count_r != {CNT_W{1'b0}}) && !redirect_i;
    pop_s          = fe_valid_o && fe_ready_i;
    push_s         = rsp_fire_s && !drop_r && !redirect_i;
  end

  assign ic_req_addr_o = npc_r;
  assign fe_pc_o       = pc_mem_r[rd_ptr_r];
  assign fe_instrs_o   = ins_mem_r[rd_ptr_r];

  // PC, outstanding/drop tracking and FIFO pointers; redirect overrides everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      npc_r         <= RESET_PC;
      req_pc_r      <= RESET_PC;
      outstanding_r <= 1'b0;
      drop_r        <= 1'b0;
      wr_ptr_r      <= {PTR_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
    end else if (redirect_i) begin
      npc_r         <= redirect_pc_i;
      outstanding_r <= outstanding_r && !rsp_fire_s;
      // An in-flight request that has not answered yet must be swallowed on arrival.
      drop_r        <= outstanding_r && !rsp_fire_s;
      wr_ptr_r      <= {PTR_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
    end else begin
      if (req_fire_s) begin
        req_pc_r <= npc_r;
        npc_r    <= npc_r + FETCH_INC;
      end
      outstanding_r <= req_fire_s || (outstanding_r && !rsp_fire_s);
      if (rsp_fire_s && drop_r) begin
        drop_r <= 1'b0;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CNT_W'(1);
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  // FIFO storage: each entry holds a response group and the PC of its first instruction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(RSP_DEPTH); i++) begin
        pc_mem_r[i]  <= {PLEN{1'b0}};
        ins_mem_r[i] <= {GW{1'b0}};
      end
    end else if (push_s) begin
      pc_mem_r[wr_ptr_r]  <= req_pc_r;
      ins_mem_r[wr_ptr_r] <= ic_rsp_instrs_i;
    end else begin
      pc_mem_r[wr_ptr_r]  <= pc_mem_r[wr_ptr_r];
      ins_mem_r[wr_ptr_r] <= ins_mem_r[wr_ptr_r];
    end
  end

  fetch_unit_chk #(
    .RSP_DEPTH (RSP_DEPTH),
    .CNT_W     (CNT_W)
  ) u_chk (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_s  (push_s),
    .pop_s   (pop_s),
    .count_r (count_r)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an I-cache responder plus directed scenarios
// and a randomized run checked against a queue-based reference model.

module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] REDIR_PC = 32'h8000_1000;

  logic         clk_i;
  logic         rst_ni;
  logic         redirect_i;
  logic [31:0]  redirect_pc_i;
  logic         ic_req_valid_o;
  logic         ic_req_ready_i  = 1'b1;
  logic [31:0]  ic_req_addr_o;
  logic         ic_rsp_valid_i  = 1'b0;
  logic [127:0] ic_rsp_instrs_i = 128'h0;
  logic         fe_valid_o;
  logic         fe_ready_i;
  logic [127:0] fe_instrs_o;
  logic [31:0]  fe_pc_o;

  int n_checks;
  int n_fail;

  int rsp_delay;
  bit rdy_random;
  bit dly_random;
  int proto_err;

  bit          ic_busy;
  int          ic_cnt;
  logic [31:0] ic_addr;

  fetch_unit dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .ic_req_valid_o  (ic_req_valid_o),
    .ic_req_ready_i  (ic_req_ready_i),
    .ic_req_addr_o   (ic_req_addr_o),
    .ic_rsp_valid_i  (ic_rsp_valid_i),
    .ic_rsp_instrs_i (ic_rsp_instrs_i),
    .fe_valid_o      (fe_valid_o),
    .fe_ready_i      (fe_ready_i),
    .fe_instrs_o     (fe_instrs_o),
    .fe_pc_o         (fe_pc_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [127:0] gen(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a + 32'd4, ~a, {a[15:0], a[31:16]}};
  endfunction

  // I-cache model: accepts a request, answers after a delay of at least one cycle.
  always begin
    @(negedge clk_i);
    ic_rsp_valid_i = 1'b0;
    if (!rst_ni) begin
      ic_busy = 1'b0;
    end else if (ic_busy) begin
      if (ic_cnt == 0) begin
        ic_rsp_valid_i  = 1'b1;
        ic_rsp_instrs_i = gen(ic_addr);
        ic_busy         = 1'b0;
      end else begin
        ic_cnt--;
      end
    end
    ic_req_ready_i = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
    #2;
    if (rst_ni && ic_req_valid_o && ic_req_ready_i) begin
      if (ic_busy) proto_err++;
      ic_busy = 1'b1;
      ic_addr = ic_req_addr_o;
      ic_cnt  = (dly_random ? int'($urandom_range(1, 4)) : rsp_delay) - 1;
    end
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni     = 1'b0;
    redirect_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rdy_random = 1'b0; dly_random = 1'b0; rsp_delay = 1; fe_ready_i = 1'b1; redirect_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (ic_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", ic_req_valid_o); end
    n_checks++;
    if (fe_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_fe_valid: got %b want 0", fe_valid_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    n_checks++;
    if (ic_req_valid_o !== 1'b1 || ic_req_addr_o !== RESET_PC) begin
      n_fail++; $display("FAIL reset_first_req: valid %b addr %h want 1 %h", ic_req_valid_o, ic_req_addr_o, RESET_PC);
    end
    n_checks++;
    if (fe_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_release_fe_valid: got %b want 0", fe_valid_o); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_a;
    logic [31:0] exp_p;
    fe_ready_i = 1'b1; rsp_delay = 1;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk_i);
      #1;
      exp_a = RESET_PC + 32'(16 * k);
      n_checks++;
      if (ic_req_valid_o !== 1'b1 || ic_req_addr_o !== exp_a) begin
        n_fail++; $display("FAIL stream_req k=%0d: valid %b addr %h want 1 %h", k, ic_req_valid_o, ic_req_addr_o, exp_a);
      end
      if (k >= 2) begin
        exp_p = RESET_PC + 32'(16 * (k - 2));
        n_checks++;
        if (fe_valid_o !== 1'b1 || fe_pc_o !== exp_p || fe_instrs_o !== gen(exp_p)) begin
          n_fail++; $display("FAIL stream_fe k=%0d: valid %b pc %h want 1 %h", k, fe_valid_o, fe_pc_o, exp_p);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int          accepted;
    int          got;
    bit          first_req;
    logic [31:0] exp_pc;
    fe_ready_i = 1'b0; rsp_delay = 1; accepted = 0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk_i);
      #1;
      if (ic_req_valid_o && ic_req_ready_i) accepted++;
    end
    n_checks++;
    if (accepted != 4) begin n_fail++; $display("FAIL bp_accepted: got %0d want 4", accepted); end
    n_checks++;
    if (ic_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_req_stalled: got %b want 0", ic_req_valid_o); end
    n_checks++;
    if (fe_valid_o !== 1'b1 || fe_pc_o !== RESET_PC) begin
      n_fail++; $display("FAIL bp_head: valid %b pc %h want 1 %h", fe_valid_o, fe_pc_o, RESET_PC);
    end
    exp_pc = RESET_PC; got = 0; first_req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      fe_ready_i = 1'b1;
      #1;
      if (fe_valid_o) begin
        n_checks++;
        if (fe_pc_o !== exp_pc || fe_instrs_o !== gen(exp_pc)) begin
          n_fail++; $display("FAIL bp_drain_order: pc %h want %h", fe_pc_o, exp_pc);
        end
        exp_pc = exp_pc + 32'd16;
        got++;
      end
      if (!first_req && ic_req_valid_o) begin
        first_req = 1'b1;
        n_checks++;
        if (ic_req_addr_o !== RESET_PC + 32'd64) begin
          n_fail++; $display("FAIL bp_resume_addr: got %h want %h", ic_req_addr_o, RESET_PC + 32'd64);
        end
      end
    end
    n_checks++;
    if (got != 12 || !first_req) begin n_fail++; $display("FAIL bp_drain_count: got %0d resumed %b want 12 1", got, first_req); end
  endtask

  task automatic test_redirect_outstanding();
    fe_ready_i = 1'b1; rsp_delay = 5;
    do_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    redirect_i = 1'b1; redirect_pc_i = REDIR_PC;
    #1;
    n_checks++;
    if (ic_req_valid_o !== 1'b0 || fe_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL t3_redirect_cycle: req %b fe %b want 0 0", ic_req_valid_o, fe_valid_o);
    end
    @(negedge clk_i);
    redirect_i = 1'b0; rsp_delay = 1;
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(negedge clk_i);
      #1;
      n_checks++;
      if (ic_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL t3_wait_drop k=%0d: req %b want 0", k, ic_req_valid_o); end
    end
    @(negedge clk_i);
    #1;
    n_checks++;
    if (ic_req_valid_o !== 1'b1 || ic_req_addr_o !== REDIR_PC) begin
      n_fail++; $display("FAIL t3_new_req: valid %b addr %h want 1 %h", ic_req_valid_o, ic_req_addr_o, REDIR_PC);
    end
    @(negedge clk_i);
    #1;
    n_checks++;
    if (fe_valid_o !== 1'b0) begin n_fail++; $display("FAIL t3_stale_pushed: fe_valid %b want 0", fe_valid_o); end
    @(negedge clk_i);
    #1;
    n_checks++;
    if (fe_valid_o !== 1'b1 || fe_pc_o !== REDIR_PC || fe_instrs_o !== gen(REDIR_PC)) begin
      n_fail++; $display("FAIL t3_first_group: valid %b pc %h want 1 %h", fe_valid_o, fe_pc_o, REDIR_PC);
    end
  endtask

  task automatic test_redirect_same_rsp();
    fe_ready_i = 1'b1; rsp_delay = 2;
    do_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    redirect_i = 1'b1; redirect_pc_i = REDIR_PC;
    #1;
    n_checks++;
    if (ic_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL t4_redirect_req: got %b want 0", ic_req_valid_o); end
    @(negedge clk_i);
    redirect_i = 1'b0;
    #1;
    n_checks++;
    if (ic_req_valid_o !== 1'b1 || ic_req_addr_o !== REDIR_PC) begin
      n_fail++; $display("FAIL t4_next_req: valid %b addr %h want 1 %h", ic_req_valid_o, ic_req_addr_o, REDIR_PC);
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk_i);
      if (k > 0) #1;
      n_checks++;
      if (fe_valid_o !== 1'b0) begin n_fail++; $display("FAIL t4_no_group k=%0d: fe_valid %b want 0", k, fe_valid_o); end
    end
    @(negedge clk_i);
    #1;
    n_checks++;
    if (fe_valid_o !== 1'b1 || fe_pc_o !== REDIR_PC) begin
      n_fail++; $display("FAIL t4_first_group: valid %b pc %h want 1 %h", fe_valid_o, fe_pc_o, REDIR_PC);
    end
  endtask

  task automatic test_redirect_queued();
    fe_ready_i = 1'b0; rsp_delay = 1;
    do_reset();
    repeat (3) @(negedge clk_i);
    #1;
    n_checks++;
    if (fe_valid_o !== 1'b1 || fe_pc_o !== RESET_PC) begin
      n_fail++; $display("FAIL t5_queued_head: valid %b pc %h want 1 %h", fe_valid_o, fe_pc_o, RESET_PC);
    end
    @(negedge clk_i);
    redirect_i = 1'b1; redirect_pc_i = REDIR_PC;
    #1;
    n_checks++;
    if (fe_valid_o !== 1'b0 || ic_req_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL t5_redirect_cycle: fe %b req %b want 0 0", fe_valid_o, ic_req_valid_o);
    end
    @(negedge clk_i);
    redirect_i = 1'b0;
    #1;
    n_checks++;
    if (fe_valid_o !== 1'b0 || ic_req_valid_o !== 1'b1 || ic_req_addr_o !== REDIR_PC) begin
      n_fail++; $display("FAIL t5_after: fe %b req %b addr %h want 0 1 %h", fe_valid_o, ic_req_valid_o, ic_req_addr_o, REDIR_PC);
    end
    repeat (2) @(negedge clk_i);
    #1;
    n_checks++;
    if (fe_valid_o !== 1'b1 || fe_pc_o !== REDIR_PC) begin
      n_fail++; $display("FAIL t5_first_group: valid %b pc %h want 1 %h", fe_valid_o, fe_pc_o, REDIR_PC);
    end
  endtask

  task automatic test_reset_midstream();
    fe_ready_i = 1'b0; rsp_delay = 1;
    do_reset();
    repeat (2) @(negedge clk_i);
    #1;
    n_checks++;
    if (fe_valid_o !== 1'b1) begin n_fail++; $display("FAIL t6_pre_valid: got %b want 1", fe_valid_o); end
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (ic_req_valid_o !== 1'b0 || fe_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL t6_async_reset: req %b fe %b want 0 0", ic_req_valid_o, fe_valid_o);
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1; fe_ready_i = 1'b1;
    #1;
    n_checks++;
    if (ic_req_valid_o !== 1'b1 || ic_req_addr_o !== RESET_PC || fe_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL t6_restart: req %b addr %h fe %b want 1 %h 0", ic_req_valid_o, ic_req_addr_o, fe_valid_o, RESET_PC);
    end
    repeat (2) @(negedge clk_i);
    #1;
    n_checks++;
    if (fe_valid_o !== 1'b1 || fe_pc_o !== RESET_PC) begin
      n_fail++; $display("FAIL t6_first_group: valid %b pc %h want 1 %h", fe_valid_o, fe_pc_o, RESET_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] exp_req;
    logic [31:0] infl_pc;
    bit          infl;
    bit          stale;
    bit          rsp;
    bit          exp_fe;
    bit          exp_rq;
    int          delivered;
    rdy_random = 1'b1; dly_random = 1'b1; fe_ready_i = 1'b0; proto_err = 0;
    do_reset();
    exp_req = RESET_PC; infl = 1'b0; stale = 1'b0; infl_pc = 32'h0; delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) begin
        @(negedge clk_i);
        fe_ready_i = ($urandom_range(0, 3) != 0);
        redirect_i = ($urandom_range(0, 24) == 0);
        if (redirect_i) redirect_pc_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFE0 : ($urandom() & 32'hFFFF_FFF0);
      end
      #1;
      rsp    = ic_rsp_valid_i;
      exp_fe = (q.size() != 0) && !redirect_i;
      exp_rq = !redirect_i && (!infl || rsp) && ((q.size() + int'(infl)) < 4);
      n_checks++;
      if (fe_valid_o !== exp_fe) begin n_fail++; $display("FAIL rnd_fe_valid c=%0d: got %b want %b", c, fe_valid_o, exp_fe); end
      if (exp_fe) begin
        n_checks++;
        if (fe_pc_o !== q[0] || fe_instrs_o !== gen(q[0])) begin
          n_fail++; $display("FAIL rnd_fe_data c=%0d: pc %h want %h", c, fe_pc_o, q[0]);
        end
      end
      n_checks++;
      if (ic_req_valid_o !== exp_rq) begin n_fail++; $display("FAIL rnd_req_valid c=%0d: got %b want %b", c, ic_req_valid_o, exp_rq); end
      if (exp_rq) begin
        n_checks++;
        if (ic_req_addr_o !== exp_req) begin n_fail++; $display("FAIL rnd_req_addr c=%0d: got %h want %h", c, ic_req_addr_o, exp_req); end
      end
      if (redirect_i) begin
        q.delete();
        stale   = infl && !rsp;
        infl    = infl && !rsp;
        exp_req = redirect_pc_i;
      end else begin
        if (exp_fe && fe_ready_i) begin
          void'(q.pop_front());
          delivered++;
        end
        if (rsp) begin
          if (stale) stale = 1'b0;
          else q.push_back(infl_pc);
          infl = 1'b0;
        end
        if (ic_req_valid_o && ic_req_ready_i) begin
          infl    = 1'b1;
          infl_pc = exp_req;
          exp_req = exp_req + 32'd16;
        end
      end
    end
    redirect_i = 1'b0;
    n_checks++;
    if (proto_err != 0) begin n_fail++; $display("FAIL rnd_one_outstanding: violations %0d want 0", proto_err); end
    n_checks++;
    if (delivered < 200) begin n_fail++; $display("FAIL rnd_progress: delivered %0d want >= 200", delivered); end
    rdy_random = 1'b0; dly_random = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; proto_err = 0;
    rst_ni = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; fe_ready_i = 1'b0;
    rsp_delay = 1; rdy_random = 1'b0; dly_random = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_same_rsp();
    test_redirect_queued();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
